// File: rtl/display_stream_fetcher_pkg.sv
// rtl/display_stream_fetcher_pkg.sv - shared types and constants for the framebuffer scan-out engine
// Contents:
//   fetch_state_e  fetch FSM encoding (IDLE=0, REQ=1)
//   WB_SEL/WB_WE/WB_DAT_O  constant Wishbone master drive values
//   slot_width()   bits per packed pixel slot in a 32-bit word
package display_stream_fetcher_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  localparam logic [3:0]  WB_SEL   = 4'b1111;
  localparam logic        WB_WE    = 1'b0;
  localparam logic [31:0] WB_DAT_O = 32'h0000_0000;

  function automatic int slot_width(input int ppw);
    return 32 / ppw;
  endfunction

endpackage

// File: rtl/display_stream_fetcher_word_fifo.sv
// rtl/display_stream_fetcher_word_fifo.sv - synchronous word FIFO with flush and occupancy count
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_flush          empty the FIFO this clock (wins over push/pop)
//   i_push, i_din    write a word (ignored when full)
//   i_pop            drop the head word (ignored when empty)
//   o_dout           head word, valid while not empty
//   o_full, o_empty  status
//   o_count          number of stored words
module display_stream_fetcher_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Storage is left unreset so it can map onto RAM; pointers guard validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/display_stream_fetcher.sv
// rtl/display_stream_fetcher.sv - Wishbone framebuffer prefetcher and per-pixel unpacker
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   gc_*_o / gc_*_i       read-only Wishbone master (single outstanding access)
//   monitor_base_address  framebuffer byte base, captured on frame
//   frame                 start-of-frame pulse: restarts fetch, flushes FIFO, clears flags
//   pixel_en, visible     pixel-rate strobe and active-area qualifier
//   color                 registered pixel, valid the clock after a qualifying pixel_en
//   underflow             sticky: visible pixel requested with FIFO empty
//   bus_error             sticky: gc_err_i terminated an access this frame
module display_stream_fetcher
  import display_stream_fetcher_pkg::*;
#(
  parameter int COLOR_W      = 3,
  parameter int PIX_PER_WORD = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        gc_dat_o,
  output logic [31:0]        gc_adr_o,
  output logic               gc_cyc_o,
  output logic               gc_stb_o,
  output logic [3:0]         gc_sel_o,
  output logic               gc_we_o,
  input  logic [31:0]        gc_dat_i,
  input  logic               gc_ack_i,
  input  logic               gc_err_i,
  input  logic [31:0]        monitor_base_address,
  input  logic               frame,
  input  logic               pixel_en,
  input  logic               visible,
  output logic [COLOR_W-1:0] color,
  output logic               underflow,
  output logic               bus_error
);

  localparam int SLOT_W      = slot_width(PIX_PER_WORD);
  localparam int FRAME_WORDS = H_RES * V_RES / PIX_PER_WORD;
  localparam int K_W         = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(PIX_PER_WORD - 1);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0]        r_base;
  logic [31:0]        r_word_idx;
  logic [31:0]        r_words_left;
  logic [31:0]        r_adr;
  logic [K_W-1:0]     r_k;
  logic [COLOR_W-1:0] r_color;
  logic               r_underflow;
  logic               r_bus_error;

  logic               w_issue;
  logic               w_resp;
  logic               w_push;
  logic [31:0]        w_push_data;
  logic               w_pop;
  logic [31:0]        w_head;
  logic [31:0]        w_shifted;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;

  assign gc_dat_o  = WB_DAT_O;
  assign gc_sel_o  = WB_SEL;
  assign gc_we_o   = WB_WE;
  assign gc_adr_o  = r_adr;
  assign gc_cyc_o  = (r_state == ST_REQ);
  assign gc_stb_o  = (r_state == ST_REQ);
  assign color     = r_color;
  assign underflow = r_underflow;
  assign bus_error = r_bus_error;

  // A response coinciding with frame belongs to the old frame and is dropped.
  assign w_resp      = (r_state == ST_REQ) && (gc_ack_i || gc_err_i);
  assign w_push      = w_resp && !frame;
  assign w_push_data = gc_err_i ? 32'h0 : gc_dat_i;

  assign w_pop     = pixel_en && visible && !frame && !w_fifo_empty && (r_k == K_LAST);
  assign w_shifted = w_head >> (SLOT_W * r_k);

  display_stream_fetcher_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (frame),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Only one access is ever outstanding and it is issued only when a slot is
  // free; pops can only add room, so the in-flight word always fits.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_words_left != 32'd0) && !w_fifo_full) begin
          w_state_nxt = ST_REQ;
          w_issue     = 1'b1;
        end
      end
      ST_REQ: begin
        if (w_resp) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (frame) begin
      w_state_nxt = ST_IDLE;
      w_issue     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base       <= 32'h0;
      r_word_idx   <= 32'h0;
      r_words_left <= 32'h0;
      r_adr        <= 32'h0;
    end else if (frame) begin
      r_base       <= monitor_base_address;
      r_word_idx   <= 32'h0;
      r_words_left <= 32'(FRAME_WORDS);
    end else begin
      if (w_issue) begin
        r_adr <= r_base + {r_word_idx[29:0], 2'b00};
      end
      if (w_push) begin
        r_word_idx   <= r_word_idx + 32'd1;
        r_words_left <= r_words_left - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_color     <= '0;
      r_k         <= '0;
      r_underflow <= 1'b0;
      r_bus_error <= 1'b0;
    end else if (frame) begin
      r_color     <= '0;
      r_k         <= '0;
      r_underflow <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_resp && gc_err_i) begin
        r_bus_error <= 1'b1;
      end
      if (pixel_en) begin
        if (!visible) begin
          r_color <= '0;
        end else if (w_fifo_empty) begin
          // Starved: blank the pixel and keep the slot index where it was.
          r_color     <= '0;
          r_underflow <= 1'b1;
        end else begin
          r_color <= w_shifted[COLOR_W-1:0];
          r_k     <= (r_k == K_LAST) ? '0 : r_k + K_W'(1);
        end
      end
    end
  end

  a_fifo_count_bound: assert property (@(posedge clk) disable iff (rst)
    (w_fifo_count <= CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_display_stream_fetcher.sv
// tb/tb_display_stream_fetcher.sv - scoreboard bench for display_stream_fetcher
module tb_display_stream_fetcher;

  localparam int FW = 8 * 2 / 4;

  logic        clk;
  logic        rst;
  logic [31:0] gc_dat_o;
  logic [31:0] gc_adr_o;
  logic        gc_cyc_o;
  logic        gc_stb_o;
  logic [3:0]  gc_sel_o;
  logic        gc_we_o;
  logic [31:0] gc_dat_i;
  logic        gc_ack_i;
  logic        gc_err_i;
  logic [31:0] monitor_base_address;
  logic        frame;
  logic        pixel_en;
  logic        visible;
  logic [2:0]  color;
  logic        underflow;
  logic        bus_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr [$];
  logic [31:0] exp_pix  [$];
  logic [31:0] ovr_q    [$];

  int          ack_delay     = 0;
  int          err_idx       = -1;
  int          reads_in_frame = 0;
  int          wcnt          = 0;
  bit          addr_checked  = 0;
  bit          req_frame     = 0;
  bit          frame_on_ack  = 0;
  bit          under_model   = 0;
  logic [31:0] req_base      = 32'h0;
  logic [31:0] last_color    = 32'h0;

  display_stream_fetcher #(
    .COLOR_W      (3),
    .PIX_PER_WORD (4),
    .FIFO_DEPTH   (4),
    .H_RES        (8),
    .V_RES        (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .gc_dat_o             (gc_dat_o),
    .gc_adr_o             (gc_adr_o),
    .gc_cyc_o             (gc_cyc_o),
    .gc_stb_o             (gc_stb_o),
    .gc_sel_o             (gc_sel_o),
    .gc_we_o              (gc_we_o),
    .gc_dat_i             (gc_dat_i),
    .gc_ack_i             (gc_ack_i),
    .gc_err_i             (gc_err_i),
    .monitor_base_address (monitor_base_address),
    .frame                (frame),
    .pixel_en             (pixel_en),
    .visible              (visible),
    .color                (color),
    .underflow            (underflow),
    .bus_error            (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix_of(input logic [31:0] w, input int k);
    return (w >> (8 * k)) & 32'h7;
  endfunction

  task automatic do_frame();
    frame = 1'b1;
    monitor_base_address = req_base;
    req_frame = 0;
    exp_addr.delete();
    for (int i = 0; i < FW; i++) exp_addr.push_back(req_base + 32'(4 * i));
    exp_pix.delete();
    reads_in_frame = 0;
    wcnt = 0;
    addr_checked = 0;
    under_model = 0;
  endtask

  // Wishbone slave, frame driver and expectation producer
  initial begin
    logic [31:0] word;
    bit          respond;
    bit          is_err;
    gc_ack_i = 0;
    gc_err_i = 0;
    gc_dat_i = 0;
    frame = 0;
    monitor_base_address = 0;
    forever begin
      @(negedge clk);
      gc_ack_i = 0;
      gc_err_i = 0;
      frame = 0;
      respond = 0;
      if (!rst && gc_cyc_o && gc_stb_o) begin
        if (!addr_checked) begin
          if (exp_addr.size() > 0) check_val("rd_adr", gc_adr_o, exp_addr.pop_front());
          else check_val("extra_read", {31'h0, gc_cyc_o}, 32'h0);
          addr_checked = 1;
        end
        if (wcnt >= ack_delay) begin
          respond = 1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (respond) begin
        addr_checked = 0;
        word = (ovr_q.size() > 0) ? ovr_q.pop_front() : $urandom;
        gc_dat_i = word;
        is_err = (reads_in_frame == err_idx);
        if (is_err) gc_err_i = 1;
        else gc_ack_i = 1;
        if (!(req_frame && frame_on_ack)) begin
          reads_in_frame++;
          for (int k = 0; k < 4; k++) exp_pix.push_back(is_err ? 32'h0 : pix_of(word, k));
        end
      end
      if (req_frame && (!frame_on_ack || respond)) do_frame();
    end
  end

  task automatic start_frame(input logic [31:0] b, input bit on_ack);
    int n;
    n = 0;
    req_base = b;
    frame_on_ack = on_ack;
    req_frame = 1;
    while (req_frame && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("frame_applied", {31'h0, req_frame}, 32'h0);
    req_frame = 0;
    frame_on_ack = 0;
  endtask

  task automatic drive_pix(input bit vis, input int gap);
    logic [31:0] e;
    logic [31:0] eu;
    pixel_en = 1;
    visible = vis;
    @(negedge clk);
    pixel_en = 0;
    visible = 0;
    if (!vis) begin
      e = 0;
    end else if (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
    end else begin
      e = 0;
      under_model = 1;
    end
    eu = {31'h0, under_model};
    check_val("color", {29'h0, color}, e);
    check_val("underflow", {31'h0, underflow}, eu);
    last_color = e;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_fetch_done(input string tag);
    check_val({tag, "_reads"}, reads_in_frame, FW);
    check_val({tag, "_cyc_low"}, {31'h0, gc_cyc_o}, 32'h0);
    check_val({tag, "_addr_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    int cyc_seen;
    rst = 1;
    pixel_en = 0;
    visible = 0;
    repeat (5) @(negedge clk);
    rst = 0;

    check_val("rst_color", {29'h0, color}, 0);
    check_val("rst_underflow", {31'h0, underflow}, 0);
    check_val("rst_bus_error", {31'h0, bus_error}, 0);
    check_val("rst_cyc", {31'h0, gc_cyc_o}, 0);
    check_val("rst_stb", {31'h0, gc_stb_o}, 0);
    check_val("rst_adr", gc_adr_o, 0);
    check_val("sel_const", {28'h0, gc_sel_o}, 32'hF);
    check_val("we_const", {31'h0, gc_we_o}, 0);
    check_val("dat_o_const", gc_dat_o, 0);
    cyc_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (gc_cyc_o) cyc_seen++;
    end
    check_val("no_fetch_before_frame", cyc_seen, 0);
    check_val("idle_color", {29'h0, color}, 0);

    // Four reads from 0x1000, known first words, slow pixel drain
    ack_delay = 0;
    ovr_q.push_back(32'h0403_0201);
    ovr_q.push_back(32'h0000_0506);
    start_frame(32'h0000_1000, 0);
    repeat (20) @(negedge clk);
    check_fetch_done("f1");
    for (int i = 0; i < 4; i++) drive_pix(1, 3);
    drive_pix(0, 3);
    drive_pix(1, 3);
    check_val("color_hold", {29'h0, color}, last_color);
    for (int i = 0; i < 11; i++) drive_pix(1, 3);
    drive_pix(1, 0);
    check_val("f1_bus_error", {31'h0, bus_error}, 0);

    // Slow bus: starvation then catch-up
    ack_delay = 50;
    start_frame(32'h0000_2000, 0);
    @(negedge clk);
    check_val("underflow_cleared", {31'h0, underflow}, 0);
    for (int i = 0; i < 10; i++) drive_pix(1, 0);
    repeat (260) @(negedge clk);
    check_fetch_done("f2");
    for (int i = 0; i < 16; i++) drive_pix(1, 1);

    // Frame landing on the ack of an in-flight read discards it
    ack_delay = 2;
    start_frame(32'h0000_3000, 0);
    start_frame(32'h0000_4000, 1);
    repeat (60) @(negedge clk);
    check_fetch_done("f3");
    for (int i = 0; i < 16; i++) drive_pix(1, 0);

    // Error on the second read
    ack_delay = 0;
    err_idx = 1;
    start_frame(32'h0000_5000, 0);
    repeat (30) @(negedge clk);
    check_fetch_done("f4");
    check_val("bus_error_set", {31'h0, bus_error}, 1);
    for (int i = 0; i < 16; i++) drive_pix(1, 0);
    err_idx = -1;
    start_frame(32'h0000_6000, 0);
    @(negedge clk);
    check_val("bus_error_cleared", {31'h0, bus_error}, 0);
    repeat (30) @(negedge clk);
    check_fetch_done("f5");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
